// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer turning static decoder outputs into one-cycle strobes.
// Optional macro ILLEGAL_TRAP_EN: opcodes above 18 trap (sticky until rst) instead of running as NOP.
module cpu_ctrl_fsm #(
  parameter int ULA_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [4:0]       opcode,
  input  logic [3:0]       ula_op,
  input  logic             ram_wt,
  input  logic             pc_load_req,
  input  logic             dec_in,
  input  logic             out_en,
  input  logic             ula_done,
  input  logic             in_valid,
  output logic             ir_ld,
  output logic             pc_inc,
  output logic             pc_ld,
  output logic             acc_ld,
  output logic             ram_we,
  output logic             out_stb,
  output logic             in_ack,
  output logic             ula_start,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int TW = (ULA_TIMEOUT > 1) ? $clog2(ULA_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_WAIT_ULA = 3'd4,
    S_WAIT_IN  = 3'd5,
    S_WB       = 3'd6,
    S_TRAP     = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic illegal_op;
  logic multi_cycle_op;

  assign illegal_op     = (opcode > 5'd18);
  assign multi_cycle_op = (ula_op == 4'd4) || (ula_op == 4'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_ld     = 1'b0;
    acc_ld    = 1'b0;
    ram_we    = 1'b0;
    out_stb   = 1'b0;
    in_ack    = 1'b0;
    ula_start = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_ld   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (illegal_op) begin
`ifdef ILLEGAL_TRAP_EN
          err_d   = 1'b1;
          state_d = S_TRAP;
`else
          pc_inc  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = run ? S_FETCH : S_IDLE;
`endif
        end else if (multi_cycle_op) begin
          ula_start = 1'b1;
          tmo_d     = '0;
          state_d   = S_WAIT_ULA;
        end else if (dec_in) begin
          state_d = S_WAIT_IN;
        end else begin
          acc_ld  = (ula_op != 4'd0);
          ram_we  = ram_wt;
          out_stb = out_en;
          pc_ld   = pc_load_req;
          pc_inc  = ~pc_load_req;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = run ? S_FETCH : S_IDLE;
        end
      end
      S_WAIT_ULA: begin
        // A done pulse on the final allowed cycle still counts as success.
        if (ula_done) begin
          state_d = S_WB;
        end else if (tmo_q == TW'(ULA_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_WAIT_IN: begin
        if (in_valid) begin
          in_ack  = 1'b1;
          state_d = S_WB;
        end
      end
      S_WB: begin
        acc_ld  = 1'b1;
        pc_inc  = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign state     = state_q;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Instruction-level reference model for cpu_ctrl_fsm: each instruction expands into its expected per-cycle outputs.
module tb_cpu_ctrl_fsm;

  localparam int TMO = 8;
  localparam int CW  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic [4:0] opcode = '0;
  logic [3:0] ula_op = '0;
  logic ram_wt = 1'b0, pc_load_req = 1'b0, dec_in = 1'b0, out_en = 1'b0;
  logic ula_done = 1'b0, in_valid = 1'b0;
  logic ir_ld, pc_inc, pc_ld, acc_ld, ram_we, out_stb, in_ack, ula_start, busy, err;
  logic [2:0] state;
  logic [CW-1:0] instr_cnt;

  cpu_ctrl_fsm #(.ULA_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .ula_op(ula_op),
    .ram_wt(ram_wt), .pc_load_req(pc_load_req), .dec_in(dec_in), .out_en(out_en),
    .ula_done(ula_done), .in_valid(in_valid),
    .ir_ld(ir_ld), .pc_inc(pc_inc), .pc_ld(pc_ld), .acc_ld(acc_ld), .ram_we(ram_we),
    .out_stb(out_stb), .in_ack(in_ack), .ula_start(ula_start), .busy(busy), .err(err),
    .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, run;
    logic [4:0] opc;
    logic [3:0] uop;
    logic ram_wt, plr, din, oen, done, inv;
  } in_t;

  typedef struct packed {
    logic [2:0] st;
    logic ir_ld, pc_inc, pc_ld, acc_ld, ram_we, out_stb, in_ack, ula_start, busy, err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ir_log[$];
  int acc_log[$];
  int pcld_log[$];
  int ramwe_log[$];

  int m_cnt = 0;
  bit m_err = 1'b0;
  bit m_idle = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      chk("state", 32'(state), 32'(ce.st));
      chk("ir_ld", 32'(ir_ld), 32'(ce.ir_ld));
      chk("pc_inc", 32'(pc_inc), 32'(ce.pc_inc));
      chk("pc_ld", 32'(pc_ld), 32'(ce.pc_ld));
      chk("acc_ld", 32'(acc_ld), 32'(ce.acc_ld));
      chk("ram_we", 32'(ram_we), 32'(ce.ram_we));
      chk("out_stb", 32'(out_stb), 32'(ce.out_stb));
      chk("in_ack", 32'(in_ack), 32'(ce.in_ack));
      chk("ula_start", 32'(ula_start), 32'(ce.ula_start));
      chk("busy", 32'(busy), 32'(ce.busy));
      chk("err", 32'(err), 32'(ce.err));
      chk("instr_cnt", 32'(instr_cnt), 32'(ce.cnt));
      if (ir_ld === 1'b1) ir_log.push_back(cyc);
      if (acc_ld === 1'b1) acc_log.push_back(cyc);
      if (pc_ld === 1'b1) pcld_log.push_back(cyc);
      if (ram_we === 1'b1) ramwe_log.push_back(cyc);
      cyc++;
    end
  end

  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    e.busy = (st != 3'd0);
    e.err = m_err;
    e.cnt = CW'(m_cnt);
    return e;
  endfunction

  task automatic step(input in_t i, input exp_t e);
    @(posedge clk);
    #1;
    rst = i.rst; run = i.run; opcode = i.opc; ula_op = i.uop;
    ram_wt = i.ram_wt; pc_load_req = i.plr; dec_in = i.din; out_en = i.oen;
    ula_done = i.done; in_valid = i.inv;
    exp_q.push_back(e);
  endtask

  task automatic retire(input bit run_end);
    m_cnt = (m_cnt + 1) % (1 << CW);
    m_idle = !run_end;
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_err = 1'b0;
    m_idle = 1'b1;
  endtask

  task automatic idle_cycle(input bit do_rst);
    in_t c;
    c = '0;
    c.rst = do_rst;
    step(c, base(3'd0));
    if (do_rst) model_reset();
  endtask

  // lat: cycles until ula_done for MLT/DIV (beyond TMO means timeout), or idle cycles before in_valid for IN.
  task automatic run_instr(input logic [4:0] opc, input logic [3:0] uop, input logic ram_wt_i,
                           input logic plr, input logic din, input logic oen,
                           input int lat, input bit run_end, input bit rst_exec);
    in_t c;
    exp_t e;
    bit illegal, mlt;
    c = '0;
    c.opc = opc; c.uop = uop; c.ram_wt = ram_wt_i; c.plr = plr; c.din = din; c.oen = oen;
    illegal = (opc > 5'd18);
    mlt = (uop == 4'd4) || (uop == 4'd5);
    if (m_idle) begin
      c.run = 1'b1;
      step(c, base(3'd0));
    end
    c.run = 1'($urandom_range(0, 1)); c.inv = 1'($urandom_range(0, 1));
    e = base(3'd1); e.ir_ld = 1'b1;
    step(c, e);
    c.run = 1'($urandom_range(0, 1)); c.inv = 1'($urandom_range(0, 1));
    step(c, base(3'd2));
    c.inv = 1'b0;
    e = base(3'd3);
    if (illegal) begin
`ifndef ILLEGAL_TRAP_EN
      e.pc_inc = 1'b1;
`endif
    end else if (mlt) begin
      e.ula_start = 1'b1;
    end else if (!din) begin
      e.acc_ld = (uop != 4'd0); e.ram_we = ram_wt_i; e.out_stb = oen;
      e.pc_ld = plr; e.pc_inc = !plr;
    end
    c.run = run_end;
    if (rst_exec) begin
      c.rst = 1'b1;
      step(c, e);
      model_reset();
      return;
    end
    step(c, e);
    if (illegal) begin
`ifdef ILLEGAL_TRAP_EN
      m_err = 1'b1;
      for (int k = 0; k < 4; k++) begin
        c.run = 1'($urandom_range(0, 1));
        step(c, base(3'd7));
      end
      c.rst = 1'b1;
      step(c, base(3'd7));
      model_reset();
`else
      retire(run_end);
`endif
      return;
    end
    if (!mlt && !din) begin
      retire(run_end);
      return;
    end
    if (mlt) begin
      for (int k = 0; k < TMO; k++) begin
        c.run = 1'($urandom_range(0, 1));
        c.done = (k == lat - 1);
        step(c, base(3'd4));
        if (c.done) break;
        if (k == TMO - 1) begin
          m_err = 1'b1;
          m_idle = 1'b1;
          return;
        end
      end
      c.done = 1'b0;
    end else begin
      for (int k = 0; k < lat; k++) begin
        c.run = 1'($urandom_range(0, 1));
        step(c, base(3'd5));
      end
      c.inv = 1'b1;
      e = base(3'd5); e.in_ack = 1'b1;
      step(c, e);
      c.inv = 1'b0;
    end
    c.run = run_end;
    e = base(3'd6); e.acc_ld = 1'b1; e.pc_inc = 1'b1;
    step(c, e);
    retire(run_end);
  endtask

  initial begin
    int cls, lat, u;
    logic [4:0] opc;
    logic [3:0] uop;
    logic din;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // ADD, then taken JZ, then SET (store, no accumulator load)
    run_instr(5'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    chk("model_cnt_add", 32'(m_cnt), 32'd1);
    run_instr(5'd12, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    run_instr(5'd3, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("pin_first_ir", ir_log.size() > 0 ? ir_log[0] : -1, 32'd1);
    chk("pin_add_acc", acc_log.size() > 0 ? acc_log[0] : -1, 32'd3);
    chk("pin_second_ir", ir_log.size() > 1 ? ir_log[1] : -1, 32'd4);
    chk("pin_jz_pcld", pcld_log.size() > 0 ? pcld_log[0] : -1, 32'd6);
    chk("pin_set_ramwe", ramwe_log.size() > 0 ? ramwe_log[0] : -1, 32'd9);
    chk("pin_acc_count", 32'(acc_log.size()), 32'd1);
    chk("model_cnt_3", 32'(m_cnt), 32'd3);

    run_instr(5'd7, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    run_instr(5'd9, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0);
    run_instr(5'd8, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, TMO, 1'b1, 1'b0);
    chk("model_err_clear", 32'(m_err), 32'd0);
    run_instr(5'd7, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 20, 1'b1, 1'b0);
    chk("model_err_tmo", 32'(m_err), 32'd1);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    run_instr(5'd25, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    run_instr(5'd2, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1);

    for (int n = 0; n < 300; n++) begin
      if (m_idle && $urandom_range(0, 3) == 0)
        idle_cycle($urandom_range(0, 4) == 0);
      cls = $urandom_range(0, 9);
      u = $urandom_range(0, 13);
      uop = 4'((u >= 4) ? u + 2 : u);
      opc = 5'($urandom_range(0, 18));
      din = 1'b0;
      lat = 0;
      if (cls == 5 || cls == 6) begin
        uop = 4'(4 + $urandom_range(0, 1));
        lat = $urandom_range(1, TMO + 2);
      end else if (cls == 7 || cls == 8) begin
        din = 1'b1;
        lat = $urandom_range(0, 6);
      end else if (cls == 9) begin
        opc = 5'($urandom_range(19, 31));
      end
      run_instr(opc, uop, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), din,
                1'($urandom_range(0, 1)), lat, $urandom_range(0, 3) != 0,
                $urandom_range(0, 29) == 0);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
